bus_rr_arbit_nxm: RTL and testbench

//  Parametrised shared bus: NUM_M masters, NUM_S slaves, round-robin arbitration.

---
 rtl/bus_rr_arbit_nxm_if.sv | 30 +++
 rtl/bus_rr_arbit_nxm.sv | 121 ++++++++++++
 tb/tb_bus_rr_arbit_nxm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbit_nxm_if.sv
// Shared-bus signal bundle for the NUM_M x NUM_S round-robin bus.
// The slave modport is the arbiter side; the master modport is the engine/memory side.
interface bus_rr_arbit_nxm_if #(
    parameter int NUM_M = 4,
    parameter int NUM_S = 4,
    parameter int AW    = 8,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    M_req;
    logic [NUM_M-1:0]    M_wr;
    logic [NUM_M*AW-1:0] M_address;
    logic [NUM_M*DW-1:0] M_dout;
    logic [NUM_S*DW-1:0] S_dout;
    logic [NUM_M-1:0]    M_grant;
    logic [DW-1:0]       M_din;
    logic [NUM_S-1:0]    S_sel;
    logic [AW-1:0]       S_address;
    logic                S_wr;
    logic [DW-1:0]       S_din;

    modport slave (
        input  M_req, M_wr, M_address, M_dout, S_dout,
        output M_grant, M_din, S_sel, S_address, S_wr, S_din
    );

    modport master (
        output M_req, M_wr, M_address, M_dout, S_dout,
        input  M_grant, M_din, S_sel, S_address, S_wr, S_din
    );
endinterface

// File: rtl/bus_rr_arbit_nxm.sv
// Round-robin, non-preemptive shared bus: registered one-hot grant, combinational
// address decode to a one-hot slave select, read data returned via a registered select.
module bus_rr_arbit_nxm #(
    parameter int NUM_M = 4,
    parameter int NUM_S = 4,
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int SB    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_rr_arbit_nxm_if.slave bus
);
    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state_reg, state_next;
    logic [NUM_M-1:0] grant_reg, grant_next;
    logic [PW-1:0]    owner_reg, owner_next;
    logic [PW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [NUM_S-1:0] sel_q;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic             owned;
    logic [SB-1:0]    slave_idx;
    logic [DW-1:0]    din_terms [NUM_S];
    logic [DW-1:0]    din_acc;

    // First requester after the last winner, wrapping modulo NUM_M.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            j = (int'(rr_ptr_reg) + k) % NUM_M;
            if (!win_found && bus.M_req[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next  = OWNED;
                    grant_next  = NUM_M'(1) << win_idx;
                    owner_next  = win_idx;
                    rr_ptr_next = win_idx;
                end
            end
            OWNED: begin
                // Owner keeps the bus for as long as it requests; the drop edge is the handoff edge.
                if (!bus.M_req[owner_reg]) begin
                    if (win_found) begin
                        grant_next  = NUM_M'(1) << win_idx;
                        owner_next  = win_idx;
                        rr_ptr_next = win_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            owner_reg  <= '0;
            rr_ptr_reg <= PW'(NUM_M - 1);
            sel_q      <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            sel_q      <= bus.S_sel;
        end
    end

    assign owned       = (state_reg == OWNED);
    assign bus.M_grant = grant_reg;

    assign bus.S_address = owned ? bus.M_address[owner_reg*AW +: AW] : '0;
    assign bus.S_wr      = owned & bus.M_wr[owner_reg];
    assign bus.S_din     = owned ? bus.M_dout[owner_reg*DW +: DW] : '0;

    // Indices at or above NUM_S match no select bit, so such accesses go nowhere.
    assign slave_idx = bus.S_address[AW-1 -: SB];

    generate
        for (genvar gi = 0; gi < NUM_S; gi++) begin : g_slave
            assign bus.S_sel[gi]  = owned && (slave_idx == SB'(gi));
            assign din_terms[gi]  = sel_q[gi] ? bus.S_dout[gi*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        din_acc = '0;
        for (int s = 0; s < NUM_S; s++) begin
            din_acc = din_acc | din_terms[s];
        end
    end

    assign bus.M_din = din_acc;
endmodule

// File: tb/tb_bus_rr_arbit_nxm.sv
// Directed bench for bus_rr_arbit_nxm: a 4x4 instance plus a 4x3 instance fed the same
// master traffic so the unmapped-slave behaviour can be observed alongside.
module tb_bus_rr_arbit_nxm;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    bus_rr_arbit_nxm_if #(.NUM_M(4), .NUM_S(4), .AW(8), .DW(32)) bus  ();
    bus_rr_arbit_nxm_if #(.NUM_M(4), .NUM_S(3), .AW(8), .DW(32)) bus3 ();

    bus_rr_arbit_nxm #(.NUM_M(4), .NUM_S(4), .AW(8), .DW(32), .SB(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bus_rr_arbit_nxm #(.NUM_M(4), .NUM_S(3), .AW(8), .DW(32), .SB(2)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    assign bus3.M_req     = bus.M_req;
    assign bus3.M_wr      = bus.M_wr;
    assign bus3.M_address = bus.M_address;
    assign bus3.M_dout    = bus.M_dout;
    assign bus3.S_dout    = bus.S_dout[3*32-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 64'(bus.M_grant),   64'h0);
        chk({tag, ".sel"},   64'(bus.S_sel),     64'h0);
        chk({tag, ".wr"},    64'(bus.S_wr),      64'h0);
        chk({tag, ".addr"},  64'(bus.S_address), 64'h0);
        chk({tag, ".sdin"},  64'(bus.S_din),     64'h0);
        chk({tag, ".mdin"},  64'(bus.M_din),     64'h0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.M_req     = 4'b0000;
        bus.M_wr      = 4'b0000;
        bus.M_address = {8'hC0, 8'h80, 8'h40, 8'h00};
        bus.M_dout    = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        bus.S_dout    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

        tick();
        tick();
        chk_idle("reset");
        $display("step reset: grant=%b sel=%b mdin=%h", bus.M_grant, bus.S_sel, bus.M_din);

        // Test 1/3/4: all four request, each drops after one cycle of ownership.
        reset_n  = 1'b1;
        bus.M_req = 4'b1111;
        bus.M_wr  = 4'b1000;
        tick();
        chk("t1.grant_m0", 64'(bus.M_grant),   64'b0001);
        chk("t1.sel_m0",   64'(bus.S_sel),     64'b0001);
        chk("t1.wr_m0",    64'(bus.S_wr),      64'h0);
        $display("step t1 m0: grant=%b sel=%b addr=%h", bus.M_grant, bus.S_sel, bus.S_address);
        bus.M_req = 4'b1110;
        tick();
        chk("t1.grant_m1", 64'(bus.M_grant),   64'b0010);
        chk("t3.sel_m1",   64'(bus.S_sel),     64'b0010);
        chk("t3.addr_m1",  64'(bus.S_address), 64'h40);
        chk("t3.sdin_m1",  64'(bus.S_din),     64'hA1);
        chk("t1.mdin_s0",  64'(bus.M_din),     64'h1111_1111);
        $display("step t1 m1: grant=%b sel=%b addr=%h mdin=%h", bus.M_grant, bus.S_sel, bus.S_address, bus.M_din);
        bus.M_req = 4'b1100;
        tick();
        chk("t1.grant_m2", 64'(bus.M_grant),   64'b0100);
        chk("t3.mdin_s1",  64'(bus.M_din),     64'hDEAD_BEEF);
        $display("step t1 m2: grant=%b mdin=%h", bus.M_grant, bus.M_din);
        bus.M_req = 4'b1000;
        tick();
        chk("t1.grant_m3", 64'(bus.M_grant),   64'b1000);
        chk("t4.wr_m3",    64'(bus.S_wr),      64'h1);
        chk("t4.sdin_m3",  64'(bus.S_din),     64'hA3);
        chk("t4.sel4_m3",  64'(bus.S_sel),     64'b1000);
        chk("t4.sel3_m3",  64'(bus3.S_sel),    64'b000);
        chk("t1.mdin_s2",  64'(bus.M_din),     64'h2222_2222);
        $display("step t1 m3: grant=%b sel=%b sel3=%b wr=%b", bus.M_grant, bus.S_sel, bus3.S_sel, bus.S_wr);
        bus.M_req = 4'b0000;
        bus.M_wr  = 4'b0000;
        tick();
        chk("t1.grant_idle", 64'(bus.M_grant), 64'h0);
        chk("t4.mdin_s3",    64'(bus.M_din),   64'h3333_3333);
        chk("t4.mdin3_unm",  64'(bus3.M_din),  64'h0);
        $display("step t1 idle: grant=%b mdin=%h mdin3=%h", bus.M_grant, bus.M_din, bus3.M_din);

        // Test 6: quiet bus.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_idle($sformatf("t6.c%0d", c));
            $display("step t6 cycle %0d: grant=%b sel=%b wr=%b mdin=%h", c, bus.M_grant, bus.S_sel, bus.S_wr, bus.M_din);
        end

        // Test 2: M2 holds through 10 cycles of contention, then M3 is skipped.
        bus.M_req = 4'b0100;
        tick();
        chk("t2.grant_m2", 64'(bus.M_grant), 64'b0100);
        bus.M_req = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t2.hold%0d", c), 64'(bus.M_grant), 64'b0100);
            $display("step t2 hold %0d: grant=%b", c, bus.M_grant);
        end
        bus.M_req = 4'b0011;
        tick();
        chk("t2.grant_m0", 64'(bus.M_grant), 64'b0001);
        $display("step t2 handoff: grant=%b", bus.M_grant);
        bus.M_req = 4'b0000;
        tick();
        chk("t2.grant_idle", 64'(bus.M_grant), 64'h0);

        // Test 5: reset while M3 owns the bus mid-write.
        bus.M_req = 4'b1000;
        bus.M_wr  = 4'b1000;
        tick();
        chk("t5.grant_m3", 64'(bus.M_grant), 64'b1000);
        chk("t5.wr_m3",    64'(bus.S_wr),    64'h1);
        bus.M_req = 4'b1001;
        reset_n   = 1'b0;
        tick();
        chk_idle("t5.rst");
        $display("step t5 reset: grant=%b sel=%b wr=%b mdin=%h", bus.M_grant, bus.S_sel, bus.S_wr, bus.M_din);
        reset_n = 1'b1;
        tick();
        chk("t5.regrant_m0", 64'(bus.M_grant), 64'b0001);
        chk("t5.wr_m0",      64'(bus.S_wr),    64'h0);
        $display("step t5 regrant: grant=%b", bus.M_grant);
        bus.M_req = 4'b0000;
        bus.M_wr  = 4'b0000;
        tick();
        chk("t5.idle", 64'(bus.M_grant), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
